s_result_scheduler: RTL and testbench
=====================================

# s_result_scheduler

Tracks every in-flight scalar (S-register) result between issue and write-back, and generates the issue hold for S-register hazards. It takes the per-instruction delay/source/dest-enable produced by the S-register result look-up table, books the single S write port N cycles ahead, and replays the booking as the S-register write strobe, address and SBUS source select. It sits between the issue stage and the S-register file, alongside the A-register scheduler.

## Interface
- `DEPTH`, default 15: booking slots; the maximum usable delay equals `DEPTH` (15 cycles, covering a 4-bit delay).
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_issue`  in  1  issue stage presents an instruction this cycle.
- `i_s_dest_en`  in  1  instruction writes an S register (from the LUT).
- `i_s_dest`  in  3  destination S register (i field).
- `i_delay`  in  4  cycles until the result is valid (from the LUT).
- `i_src`  in  5  SBUS source code (from the LUT).
- `i_sj_en`, `i_sk_en`  in  1 each  the instruction reads Sj / Sk.
- `i_sj`, `i_sk`  in  3 each  S operand indices.
- `i_clear`  in  1  synchronous flush of all bookings (exchange/deadstart).
- `o_hold`  out  1  combinational: issue must stall this cycle.
- `o_s_we`  out  1  S-register write strobe.
- `o_s_wa`  out  3  S-register write address.
- `o_s_src`  out  5  SBUS source select for the write.
- `o_s_res`  out  8  per-register reservation bits.
- `o_busy`  out  1  any booking outstanding.

## Operation
- Slot array `slot[0..DEPTH-1]`, each entry holding {valid, dest[2:0], src[4:0]}. `o_s_we/o_s_wa/o_s_src` are driven directly from `slot[0]`. The outputs are 0 when `slot[0]` is invalid.
- Every cycle `slot[i] <= slot[i+1]` and the top slot loads empty.
- Effective delay `d = (i_delay==0) ? 1 : i_delay`. It applies only when `i_s_dest_en=1`.
- The hold is the OR of the following terms, all gated by `i_issue`:
  - RAW: (`i_sj_en` & `o_s_res[i_sj]`) | (`i_sk_en` & `o_s_res[i_sk]`).
  - WAW: `i_s_dest_en` & `o_s_res[i_s_dest]`.
  - Port conflict: `i_s_dest_en` & (d < `DEPTH`) & `slot[d].valid`. This is the entry that would shift into the same slot. When d = `DEPTH` there is never a port conflict.
- Accept is `i_issue & !o_hold & i_s_dest_en`. On accept:
  - `slot[d-1]` loads {1, `i_s_dest`, `i_src`}, overriding the shift into that slot, which the conflict check guarantees is empty.
  - `o_s_res[i_s_dest]` is set.
- Reservation clear: `o_s_res[o_s_wa]` clears on the edge at which `o_s_we=1`. A same-cycle issue to that register has already been held by WAW, so set and clear never collide.
- No bypass: a reader of register r is held through the cycle in which r is written, and issues the next cycle.
- An issue with `i_s_dest_en=0` and no RAW hazard passes without booking.
- `i_clear=1`: all slots invalid and `o_s_res=0` at the next edge. An accept in the same cycle is discarded; the clear wins. `o_hold` is not affected by `i_clear`.
- `o_busy = |valid[DEPTH-1:0]`.

## Timing
- Reset (`rst=0`, asynchronous): all slots invalid, `o_s_res=0`, `o_s_we=0`, `o_s_wa=0`, `o_s_src=0`, `o_busy=0`. `o_hold` goes to 0 when `i_issue=0`. Reset mid-operation drops all pending writes without emitting them.
- An instruction accepted in cycle t with effective delay d asserts `o_s_we` for exactly one cycle, cycle t+d, with its dest/src.
- `o_s_res[dest]` is high from cycle t+1 through cycle t+d inclusive, and low from cycle t+d+1.
- `o_hold` is purely combinational from the inputs and registered state, with no added latency. The stalled instruction is re-presented by issue with `i_issue` held high.
- At most one accept per cycle and at most one write per cycle, by construction.

## Test plan
- Reset, then accept dest=S3, delay=2, src=0x05 at cycle 10:
  - `o_s_we=1`, `o_s_wa=3`, `o_s_src=0x05` at cycle 12 only.
  - `o_s_res[3]=1` in cycles 11–12.
  - `o_busy=0` from cycle 13.
- Port conflict:
  - Accept dest=S1, delay=6 at cycle 0. At cycle 1, present dest=S2, delay=5: `o_hold=1` (slot[5] valid).
  - Re-presented at cycle 2: accepted. S1 is written at cycle 6 and S2 at cycle 7.
- RAW / WAW:
  - Accept dest=S4, delay=4 at cycle 0. An issue reading Sj=4 holds in cycles 1–4 and accepts in cycle 5.
  - A separate run issuing dest=S4 holds over the same window.
- Delay 0 with `i_s_dest_en=1`: treated as 1, so a write occurs in cycle t+1. Delay 15: the write occurs at t+15 and is never held for the port.
- `i_clear` with three bookings outstanding, plus a simultaneous accept: the next cycle has `o_busy=0` and `o_s_res=0`, and no `o_s_we` pulse ever appears.
- Assert `rst=0` asynchronously between clock edges with two bookings pending: all outputs go to 0 immediately, and no write occurs after release.

Source files
------------

// File: rtl/s_result_scheduler_if.sv
// ============================================================================
// s_result_scheduler_if : issue-side and S-register write-side signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface s_result_scheduler_if;
  logic       i_issue;
  logic       i_s_dest_en;
  logic [2:0] i_s_dest;
  logic [3:0] i_delay;
  logic [4:0] i_src;
  logic       i_sj_en;
  logic       i_sk_en;
  logic [2:0] i_sj;
  logic [2:0] i_sk;
  logic       i_clear;
  logic       o_hold;
  logic       o_s_we;
  logic [2:0] o_s_wa;
  logic [4:0] o_s_src;
  logic [7:0] o_s_res;
  logic       o_busy;

  modport master (
    output i_issue, i_s_dest_en, i_s_dest, i_delay, i_src,
           i_sj_en, i_sk_en, i_sj, i_sk, i_clear,
    input  o_hold, o_s_we, o_s_wa, o_s_src, o_s_res, o_busy
  );

  modport slave (
    input  i_issue, i_s_dest_en, i_s_dest, i_delay, i_src,
           i_sj_en, i_sk_en, i_sj, i_sk, i_clear,
    output o_hold, o_s_we, o_s_wa, o_s_src, o_s_res, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/s_result_scheduler.sv
// ============================================================================
// s_result_scheduler : S-register write-port booking and issue hazard hold
// Rev 1.0
// ============================================================================
`default_nettype none

module s_result_scheduler #(
  parameter int DEPTH = 15
) (
  input  wire logic           clk,
  input  wire logic           rst,
  s_result_scheduler_if.slave bus
);

  logic [DEPTH-1:0] valid;
  logic [2:0]       dest [DEPTH];
  logic [4:0]       src  [DEPTH];
  logic [7:0]       res;
  logic [7:0]       res_next;
  logic [3:0]       eff_delay;
  logic             port_conflict;
  logic             raw;
  logic             waw;
  logic             hold;
  logic             accept;

  always_comb begin
    eff_delay = (bus.i_delay == 4'd0) ? 4'd1 : bus.i_delay;
  end

  // The booking that would shift into slot[d-1] sits in slot[d] now;
  // d == DEPTH has no such slot and therefore never conflicts.
  always_comb begin
    port_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(eff_delay) == i) begin
        port_conflict = valid[i];
      end
    end
  end

  always_comb begin
    raw    = (bus.i_sj_en & res[bus.i_sj]) | (bus.i_sk_en & res[bus.i_sk]);
    waw    = bus.i_s_dest_en & res[bus.i_s_dest];
    hold   = bus.i_issue & (raw | waw | (bus.i_s_dest_en & port_conflict));
    accept = bus.i_issue & ~hold & bus.i_s_dest_en;
  end

  always_comb begin
    res_next = res;
    if (valid[0]) begin
      res_next[dest[0]] = 1'b0;
    end
    if (accept) begin
      res_next[bus.i_s_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      res   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest[i] <= '0;
        src[i]  <= '0;
      end
    end else if (bus.i_clear) begin
      valid <= '0;
      res   <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        valid[i] <= valid[i+1];
        dest[i]  <= dest[i+1];
        src[i]   <= src[i+1];
      end
      valid[DEPTH-1] <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (int'(eff_delay) - 1 == i)) begin
          valid[i] <= 1'b1;
          dest[i]  <= bus.i_s_dest;
          src[i]   <= bus.i_src;
        end
      end
      res <= res_next;
    end
  end

  assign bus.o_hold  = hold;
  assign bus.o_s_we  = valid[0];
  assign bus.o_s_wa  = valid[0] ? dest[0] : 3'd0;
  assign bus.o_s_src = valid[0] ? src[0]  : 5'd0;
  assign bus.o_s_res = res;
  assign bus.o_busy  = |valid;

endmodule

`default_nettype wire

// File: tb/tb_s_result_scheduler.sv
// ============================================================================
// tb_s_result_scheduler : directed stimulus, absolute-time booking model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_s_result_scheduler;

  logic clk;
  logic rst;
  s_result_scheduler_if bus ();

  s_result_scheduler #(.DEPTH(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: pending writes keyed by the absolute cycle in which they appear.
  logic       ring_v [32];
  logic [2:0] ring_d [32];
  logic [4:0] ring_s [32];

  initial begin
    for (int k = 0; k < 32; k++) begin
      ring_v[k] = 1'b0;
      ring_d[k] = 3'd0;
      ring_s[k] = 5'd0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff(input logic [3:0] dly);
    return (dly == 4'd0) ? 1 : int'(dly);
  endfunction

  function automatic logic [7:0] model_res();
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (ring_v[5'(cyc + k)]) r[ring_d[5'(cyc + k)]] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic model_busy();
    logic b;
    b = 1'b0;
    for (int k = 0; k < 32; k++) b = b | ring_v[k];
    return b;
  endfunction

  function automatic logic model_hold();
    logic [7:0] r;
    logic       raw, waw, port;
    r    = model_res();
    raw  = (bus.i_sj_en && r[bus.i_sj]) || (bus.i_sk_en && r[bus.i_sk]);
    waw  = bus.i_s_dest_en && r[bus.i_s_dest];
    port = bus.i_s_dest_en && ring_v[5'(cyc + eff(bus.i_delay))];
    return bus.i_issue && (raw || waw || port);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 32; k++) ring_v[k] <= 1'b0;
    end else begin
      ring_v[5'(cyc)] <= 1'b0;
      if (bus.i_issue && bus.i_s_dest_en && !model_hold()) begin
        ring_v[5'(cyc + eff(bus.i_delay))] <= 1'b1;
        ring_d[5'(cyc + eff(bus.i_delay))] <= bus.i_s_dest;
        ring_s[5'(cyc + eff(bus.i_delay))] <= bus.i_src;
      end
      if (bus.i_clear) begin
        for (int k = 0; k < 32; k++) ring_v[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("we",   32'(bus.o_s_we),  32'(ring_v[5'(cyc)]));
    check("wa",   32'(bus.o_s_wa),  ring_v[5'(cyc)] ? 32'(ring_d[5'(cyc)]) : 32'd0);
    check("src",  32'(bus.o_s_src), ring_v[5'(cyc)] ? 32'(ring_s[5'(cyc)]) : 32'd0);
    check("res",  32'(bus.o_s_res), 32'(model_res()));
    check("busy", 32'(bus.o_busy),  32'(model_busy()));
    check("hold", 32'(bus.o_hold),  32'(model_hold()));
  end

  task automatic idle();
    bus.i_issue = 1'b0; bus.i_s_dest_en = 1'b0; bus.i_s_dest = 3'd0;
    bus.i_delay = 4'd0; bus.i_src = 5'd0; bus.i_sj_en = 1'b0;
    bus.i_sk_en = 1'b0; bus.i_sj = 3'd0; bus.i_sk = 3'd0; bus.i_clear = 1'b0;
  endtask

  task automatic issue_w(input logic [2:0] dst, input logic [3:0] dly, input logic [4:0] s);
    idle();
    bus.i_issue = 1'b1; bus.i_s_dest_en = 1'b1;
    bus.i_s_dest = dst; bus.i_delay = dly; bus.i_src = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_we",   32'(bus.o_s_we), 32'd0);
    check("rst_res",  32'(bus.o_s_res), 32'd0);
    check("rst_hold", 32'(bus.o_hold), 32'd0);
    rst = 1'b1;
    tick();

    // Basic booking: S3, delay 2, src 0x05
    issue_w(3'd3, 4'd2, 5'h05); #1;
    check("t1_hold", 32'(bus.o_hold), 32'd0);
    tick(); idle(); #1;
    check("t1_we_c1",  32'(bus.o_s_we), 32'd0);
    check("t1_res_c1", 32'(bus.o_s_res), 32'h08);
    tick(); #1;
    check("t1_we_c2",  32'(bus.o_s_we), 32'd1);
    check("t1_wa_c2",  32'(bus.o_s_wa), 32'd3);
    check("t1_src_c2", 32'(bus.o_s_src), 32'h05);
    check("t1_res_c2", 32'(bus.o_s_res), 32'h08);
    tick(); #1;
    check("t1_we_c3",   32'(bus.o_s_we), 32'd0);
    check("t1_busy_c3", 32'(bus.o_busy), 32'd0);
    check("t1_res_c3",  32'(bus.o_s_res), 32'h00);
    tick();

    // Port conflict
    issue_w(3'd1, 4'd6, 5'h0A); #1;
    check("t2_hold_c0", 32'(bus.o_hold), 32'd0);
    tick(); issue_w(3'd2, 4'd5, 5'h0B); #1;
    check("t2_hold_c1", 32'(bus.o_hold), 32'd1);
    tick(); #1;
    check("t2_hold_c2", 32'(bus.o_hold), 32'd0);
    tick(); idle();
    repeat (3) tick();
    #1;
    check("t2_we_c6", 32'(bus.o_s_we), 32'd1);
    check("t2_wa_c6", 32'(bus.o_s_wa), 32'd1);
    tick(); #1;
    check("t2_we_c7",  32'(bus.o_s_we), 32'd1);
    check("t2_wa_c7",  32'(bus.o_s_wa), 32'd2);
    check("t2_src_c7", 32'(bus.o_s_src), 32'h0B);
    tick();

    // RAW on Sj
    issue_w(3'd4, 4'd4, 5'h03); #1;
    check("t3_hold_c0", 32'(bus.o_hold), 32'd0);
    tick();
    idle(); bus.i_issue = 1'b1; bus.i_sj_en = 1'b1; bus.i_sj = 3'd4;
    for (int k = 1; k <= 4; k++) begin
      #1; check("t3_raw_hold", 32'(bus.o_hold), 32'd1);
      tick();
    end
    #1; check("t3_raw_free", 32'(bus.o_hold), 32'd0);
    idle(); tick();

    // WAW on S4
    issue_w(3'd4, 4'd4, 5'h03); tick();
    issue_w(3'd4, 4'd1, 5'h04);
    for (int k = 1; k <= 4; k++) begin
      #1; check("t3_waw_hold", 32'(bus.o_hold), 32'd1);
      tick();
    end
    #1; check("t3_waw_free", 32'(bus.o_hold), 32'd0);
    tick(); idle(); #1;
    check("t3_waw_we",  32'(bus.o_s_we), 32'd1);
    check("t3_waw_src", 32'(bus.o_s_src), 32'h04);
    tick();

    // Delay 0 acts as 1
    issue_w(3'd5, 4'd0, 5'h11); tick(); idle(); #1;
    check("t4_d0_we", 32'(bus.o_s_we), 32'd1);
    check("t4_d0_wa", 32'(bus.o_s_wa), 32'd5);
    tick();

    // Delay 15 behind a delay-14 booking
    issue_w(3'd0, 4'd14, 5'h12); tick();
    issue_w(3'd6, 4'd15, 5'h1F); #1;
    check("t4_d15_hold", 32'(bus.o_hold), 32'd0);
    tick(); idle();
    repeat (12) tick();
    #1; check("t4_we_c14", 32'(bus.o_s_we), 32'd1);
    check("t4_wa_c14", 32'(bus.o_s_wa), 32'd0);
    tick(); #1; check("t4_we_c15", 32'(bus.o_s_we), 32'd0);
    tick(); #1; check("t4_we_c16", 32'(bus.o_s_we), 32'd1);
    check("t4_wa_c16",  32'(bus.o_s_wa), 32'd6);
    check("t4_src_c16", 32'(bus.o_s_src), 32'h1F);
    tick();

    // Clear with three bookings and a simultaneous accept
    issue_w(3'd1, 4'd8, 5'h01); tick();
    issue_w(3'd2, 4'd9, 5'h02); tick();
    issue_w(3'd3, 4'd10, 5'h03); tick();
    issue_w(3'd4, 4'd3, 5'h04); bus.i_clear = 1'b1; #1;
    check("t5_hold", 32'(bus.o_hold), 32'd0);
    check("t5_busy_pre", 32'(bus.o_busy), 32'd1);
    tick(); idle(); #1;
    check("t5_busy", 32'(bus.o_busy), 32'd0);
    check("t5_res",  32'(bus.o_s_res), 32'd0);
    repeat (14) begin
      check("t5_no_we", 32'(bus.o_s_we), 32'd0);
      tick(); #1;
    end

    // Asynchronous reset with two bookings pending
    issue_w(3'd1, 4'd6, 5'h01); tick();
    issue_w(3'd2, 4'd8, 5'h02); tick();
    idle(); #1;
    check("t6_busy_pre", 32'(bus.o_busy), 32'd1);
    check("t6_res_pre",  32'(bus.o_s_res), 32'h06);
    rst = 1'b0; #1;
    check("t6_busy", 32'(bus.o_busy), 32'd0);
    check("t6_res",  32'(bus.o_s_res), 32'd0);
    check("t6_we",   32'(bus.o_s_we), 32'd0);
    check("t6_wa",   32'(bus.o_s_wa), 32'd0);
    check("t6_src",  32'(bus.o_s_src), 32'd0);
    #1; rst = 1'b1;
    tick();
    repeat (12) begin
      #1; check("t6_no_we", 32'(bus.o_s_we), 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
